puf_eval_ctrl: RTL
==================

Name: puf_eval_ctrl

Overview:
Parametrised evaluation controller between the SIRC host handler and an array of NUM_PUF arbiter/PDL PUF slices. It latches one challenge plus PDL configuration on a trigger and runs VOTE_COUNT timed evaluations of the PUF array. It majority-votes each response bit and returns the voted raw response, its XOR, and per-bit stability flags with a one-cycle done pulse. It supersedes the fixed single-shot, fixed-wait controller.

Parameters:
CHALLENGE_WIDTH, 64, challenge bits driven to every PUF slice
PDL_CONFIG_WIDTH, 64, PDL delay-tuning bits
NUM_PUF, 6, number of PUF slices; sets response width
SETTLE_CYCLES, 15, cycles puf_start is held high per evaluation; must be >=1
VOTE_COUNT, 5, evaluations per trigger; must be odd and >=1; elaboration error otherwise

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
trigger  in  1  start request; sampled only in IDLE
challenge  in  CHALLENGE_WIDTH  host challenge, captured on accepted trigger
pdl_config  in  PDL_CONFIG_WIDTH  host PDL config, captured on accepted trigger
busy  out  1  high from the edge that accepts trigger through the edge that raises done
done  out  1  one-cycle pulse; results valid from this cycle on
raw_response  out  NUM_PUF  majority-voted response, held until the next done
xor_response  out  1  XOR of all raw_response bits
stable  out  NUM_PUF  bit i = 1 when all VOTE_COUNT samples of slice i agreed
puf_challenge  out  CHALLENGE_WIDTH  registered challenge to the slices
puf_config  out  PDL_CONFIG_WIDTH  registered config to the slices
puf_start  out  1  launch signal to the slices
puf_reset  out  1  active-high hold/clear to the slices
puf_response  in  NUM_PUF  slice arbiter outputs; sampled only in SAMPLE

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, raw_response=0, xor_response=0, stable=0, puf_challenge=0, puf_config=0, puf_start=0, puf_reset=1; vote counters and round/settle counters cleared. Reset mid-run aborts with no done pulse.
- States: IDLE, ARM, EVAL, SAMPLE, FINISH. All outputs are registered.
- IDLE: puf_reset=1, puf_start=0. If trigger=1: capture challenge/pdl_config into puf_challenge/puf_config; clear vote counters and round counter; busy<=1; go to ARM.
- ARM (1 cycle): puf_reset=1; go to EVAL; settle counter <=0.
- EVAL: puf_reset=0, puf_start=1. Settle counter increments each cycle. After SETTLE_CYCLES cycles in EVAL, go to SAMPLE.
- SAMPLE (1 cycle): puf_start=0, puf_reset=1. For each i, vote_cnt[i] += puf_response[i]. Round counter increments. If round counter reaches VOTE_COUNT, go to FINISH; otherwise go to ARM.
- FINISH (1 cycle):
  - raw_response[i] = (vote_cnt[i] > VOTE_COUNT/2).
  - stable[i] = (vote_cnt[i]==0) or (vote_cnt[i]==VOTE_COUNT).
  - xor_response = reduction XOR of the new raw_response.
  - done<=1, busy<=0, state<=IDLE.
- done deasserts on the next edge.
- Latency: done is high exactly VOTE_COUNT*(SETTLE_CYCLES+2)+1 edges after the trigger-accepting edge. Defaults give 86.
- Vote counter width is clog2(VOTE_COUNT+1). No overflow is possible because a counter takes at most VOTE_COUNT increments.
- Trigger while busy is ignored and never queued. Trigger in the done cycle is accepted, since the state is already IDLE.
- challenge and pdl_config changes after acceptance have no effect until the next accepted trigger.
- VOTE_COUNT=1 degenerates to single-shot: stable is all ones.

Decomposition:
- Package puf_pkg holds:
  - the state encoding (IDLE..FINISH);
  - default width constants (CHALLENGE_WIDTH=64, PDL_CONFIG_WIDTH=64, NUM_PUF=6);
  - a clog2 function for counter sizing.
- Sub-module puf_vote_counter, one per slice, generated NUM_PUF times. Ports: clk, reset, clear, sample_en, bit_in, out count. Combinational outputs: majority, unanimous.
- The FSM and timing counters stay in puf_eval_ctrl.

Test Plan:
- Defaults; trigger=1 for one cycle with challenge=64'hDEADBEEF_01234567; puf_response model returns 6'b101100 every round -> done at exactly 86 edges after acceptance; raw_response=6'b101100, xor_response=1, stable=6'b111111; puf_challenge=64'hDEADBEEF_01234567; puf_start high for 15 cycles in each of 5 windows.
- Noisy model: bit0 returns 1,0,1,0,1 across rounds, other bits 0 -> raw_response=6'b000001, stable=6'b111110, xor_response=1.
- Trigger pulsed again at cycles 10 and 40 of a run -> single done pulse at 86, no second run started; trigger held high through done -> a new run is accepted on the done cycle.
- Assert reset=0 asynchronously mid-EVAL of round 3 -> puf_start drops immediately, puf_reset=1, all outputs are 0; no done pulse; a subsequent trigger yields a normal 86-cycle run.
- Parameter sweep SETTLE_CYCLES=1, VOTE_COUNT=1, NUM_PUF=1 -> done 4 edges after acceptance; raw_response equals the sampled bit; stable=1.

Source files
------------

// File: rtl/puf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_pkg : shared types, default widths and sizing helper for puf_eval_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_EVAL   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int c_challenge_width  = 64;
  localparam int c_pdl_config_width = 64;
  localparam int c_num_puf          = 6;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_eval_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_eval_ctrl_if : controller <-> PUF slice array bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface puf_eval_ctrl_if
  import puf_pkg::*;
#(
  parameter int CHALLENGE_WIDTH  = c_challenge_width,
  parameter int PDL_CONFIG_WIDTH = c_pdl_config_width,
  parameter int NUM_PUF          = c_num_puf
);
  logic [CHALLENGE_WIDTH-1:0]  puf_challenge;
  logic [PDL_CONFIG_WIDTH-1:0] puf_config;
  logic                        puf_start;
  logic                        puf_reset;
  logic [NUM_PUF-1:0]          puf_response;

  modport master (
    output puf_challenge,
    output puf_config,
    output puf_start,
    output puf_reset,
    input  puf_response
  );

  modport slave (
    input  puf_challenge,
    input  puf_config,
    input  puf_start,
    input  puf_reset,
    output puf_response
  );
endinterface
`default_nettype wire

// File: rtl/puf_vote_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_vote_counter : counts the ones seen on one PUF slice across evaluations
// Revision: 1.0
// ---------------------------------------------------------------------------
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int VOTE_COUNT = 5,
  parameter int CNT_W      = clog2(VOTE_COUNT + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             sample_en,
  input  wire logic             bit_in,
  output logic [CNT_W-1:0]      count,
  output logic                  majority,
  output logic                  unanimous
);

  localparam logic [CNT_W-1:0] c_half = CNT_W'(VOTE_COUNT / 2);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(VOTE_COUNT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (sample_en) begin
      count_d = count_q + CNT_W'(bit_in);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign majority  = (count_q > c_half);
  assign unanimous = (count_q == '0) || (count_q == c_full);

endmodule
`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_eval_ctrl : runs VOTE_COUNT timed PUF evaluations per trigger and
//                 returns the majority-voted response with stability flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHALLENGE_WIDTH  = c_challenge_width,
  parameter int PDL_CONFIG_WIDTH = c_pdl_config_width,
  parameter int NUM_PUF          = c_num_puf,
  parameter int SETTLE_CYCLES    = 15,
  parameter int VOTE_COUNT       = 5
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  input  wire logic                        trigger,
  input  wire logic [CHALLENGE_WIDTH-1:0]  challenge,
  input  wire logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_PUF-1:0]               raw_response,
  output logic                             xor_response,
  output logic [NUM_PUF-1:0]               stable,
  puf_eval_ctrl_if.master                  puf
);

  localparam int c_cnt_w    = clog2(VOTE_COUNT + 1);
  localparam int c_settle_w = clog2(SETTLE_CYCLES);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]    c_round_last  = c_cnt_w'(VOTE_COUNT - 1);

  generate
    if ((VOTE_COUNT < 1) || ((VOTE_COUNT % 2) == 0) || (SETTLE_CYCLES < 1)) begin : g_bad_params
      $error("puf_eval_ctrl: VOTE_COUNT must be odd and >=1, SETTLE_CYCLES >=1");
    end
  endgenerate

  state_e                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [NUM_PUF-1:0]          raw_q, raw_d;
  logic                        xor_q, xor_d;
  logic [NUM_PUF-1:0]          stable_q, stable_d;
  logic [CHALLENGE_WIDTH-1:0]  chal_q, chal_d;
  logic [PDL_CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic                        start_q, start_d;
  logic                        preset_q, preset_d;
  logic [c_cnt_w-1:0]          round_q, round_d;
  logic [c_settle_w-1:0]       settle_q, settle_d;

  logic                        vote_clear;
  logic                        vote_sample;
  logic [NUM_PUF-1:0]          vote_majority;
  logic [NUM_PUF-1:0]          vote_unanimous;
  logic [NUM_PUF-1:0][c_cnt_w-1:0] vote_cnt;
  logic                        unused_vote_cnt;

  generate
    for (genvar i = 0; i < NUM_PUF; i++) begin : g_vote
      puf_vote_counter #(
        .VOTE_COUNT (VOTE_COUNT),
        .CNT_W      (c_cnt_w)
      ) u_vote (
        .clk       (clk),
        .reset     (reset),
        .clear     (vote_clear),
        .sample_en (vote_sample),
        .bit_in    (puf.puf_response[i]),
        .count     (vote_cnt[i]),
        .majority  (vote_majority[i]),
        .unanimous (vote_unanimous[i])
      );
    end
  endgenerate

  // Raw counts are observation-only; the verdict comes from majority/unanimous.
  assign unused_vote_cnt = ^vote_cnt;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    raw_d       = raw_q;
    xor_d       = xor_q;
    stable_d    = stable_q;
    chal_d      = chal_q;
    cfg_d       = cfg_q;
    round_d     = round_q;
    settle_d    = settle_q;
    vote_clear  = 1'b0;
    vote_sample = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          chal_d     = challenge;
          cfg_d      = pdl_config;
          vote_clear = 1'b1;
          round_d    = '0;
          busy_d     = 1'b1;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        settle_d = '0;
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        settle_d = settle_q + c_settle_w'(1);
        if (settle_q == c_settle_last) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        vote_sample = 1'b1;
        round_d     = round_q + c_cnt_w'(1);
        state_d     = (round_q == c_round_last) ? ST_FINISH : ST_ARM;
      end
      ST_FINISH: begin
        raw_d    = vote_majority;
        stable_d = vote_unanimous;
        xor_d    = ^vote_majority;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Slice controls are registered from the next state so they line up with it.
    start_d  = (state_d == ST_EVAL);
    preset_d = (state_d != ST_EVAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      raw_q    <= '0;
      xor_q    <= 1'b0;
      stable_q <= '0;
      chal_q   <= '0;
      cfg_q    <= '0;
      start_q  <= 1'b0;
      preset_q <= 1'b1;
      round_q  <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      raw_q    <= raw_d;
      xor_q    <= xor_d;
      stable_q <= stable_d;
      chal_q   <= chal_d;
      cfg_q    <= cfg_d;
      start_q  <= start_d;
      preset_q <= preset_d;
      round_q  <= round_d;
      settle_q <= settle_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign raw_response      = raw_q;
  assign xor_response      = xor_q;
  assign stable            = stable_q;
  assign puf.puf_challenge = chal_q;
  assign puf.puf_config    = cfg_q;
  assign puf.puf_start     = start_q;
  assign puf.puf_reset     = preset_q;

endmodule
`default_nettype wire
